// File: rtl/ftdi_async_fifo_ctrl.sv
// FT245-style async FIFO sequencer: shares the 8-bit FTDI bus between host reads and host writes, with a deferred SIWU# flush.
// Strobes, OE and data are registered; TX_READY is combinational in IDLE. A pending RX byte blocks further reads.
module ftdi_async_fifo_ctrl #(
    parameter int RD_LOW     = 4,
    parameter int WR_SETUP   = 1,
    parameter int WR_LOW     = 2,
    parameter int RECOVER    = 3,
    parameter int FLUSH_IDLE = 64,
    parameter int SIWU_LOW   = 2
) (
    input  logic       SYSCLK,
    input  logic       RST,
    input  logic       FTDI_RXF_N,
    input  logic       FTDI_TXE_N,
    input  logic [7:0] FTDI_D_I,
    output logic [7:0] FTDI_D_O,
    output logic       FTDI_D_OE,
    output logic       FTDI_RD_N,
    output logic       FTDI_WR_N,
    output logic       FTDI_SIWU_N,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_STROBE,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_RECOVER,
        ST_SIWU
    } state_t;

    localparam int IDLE_W = $clog2(FLUSH_IDLE + 1);
    localparam int CNT_W  = 8;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              rxf_meta_q, rxf_s_q, txe_meta_q, txe_s_q;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              siwu_n_q, siwu_n_d;
    logic              d_oe_q, d_oe_d;
    logic [7:0]        d_o_q, d_o_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              flush_pend_q, flush_pend_d;
    logic              last_grant_tx_q, last_grant_tx_d;

    logic rx_req, tx_req, grant_rx, grant_tx, cnt_done;

    assign rx_req   = !rxf_s_q && !rx_valid_q;
    assign tx_req   = !txe_s_q && TX_VALID;
    // On a tie, the side not served last time wins.
    assign grant_rx = rx_req && (!tx_req || last_grant_tx_q);
    assign grant_tx = tx_req && !grant_rx;
    assign cnt_done = (cnt_q == '0);

    assign TX_READY    = (state_q == ST_IDLE) && grant_tx;
    assign FTDI_D_O    = d_o_q;
    assign FTDI_D_OE   = d_oe_q;
    assign FTDI_RD_N   = rd_n_q;
    assign FTDI_WR_N   = wr_n_q;
    assign FTDI_SIWU_N = siwu_n_q;
    assign RX_DATA     = rx_data_q;
    assign RX_VALID    = rx_valid_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        idle_cnt_d      = idle_cnt_q;
        rd_n_d          = rd_n_q;
        wr_n_d          = wr_n_q;
        siwu_n_d        = siwu_n_q;
        d_oe_d          = d_oe_q;
        d_o_d           = d_o_q;
        rx_data_d       = rx_data_q;
        rx_valid_d      = rx_valid_q;
        flush_pend_d    = flush_pend_q;
        last_grant_tx_d = last_grant_tx_q;

        if (rx_valid_q && RX_READY) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_rx) begin
                    state_d         = ST_RD_STROBE;
                    cnt_d           = CNT_W'(RD_LOW - 1);
                    rd_n_d          = 1'b0;
                    last_grant_tx_d = 1'b0;
                    idle_cnt_d      = '0;
                end else if (grant_tx) begin
                    state_d         = ST_WR_SETUP;
                    cnt_d           = CNT_W'(WR_SETUP - 1);
                    d_o_d           = TX_DATA;
                    d_oe_d          = 1'b1;
                    last_grant_tx_d = 1'b1;
                    flush_pend_d    = 1'b1;
                    idle_cnt_d      = '0;
                end else if (flush_pend_q) begin
                    if (idle_cnt_q == IDLE_W'(FLUSH_IDLE)) begin
                        state_d  = ST_SIWU;
                        cnt_d    = CNT_W'(SIWU_LOW - 1);
                        siwu_n_d = 1'b0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
            end
            ST_RD_STROBE: begin
                if (cnt_done) begin
                    rx_data_d  = FTDI_D_I;
                    rx_valid_d = 1'b1;
                    rd_n_d     = 1'b1;
                    state_d    = ST_RECOVER;
                    cnt_d      = CNT_W'(RECOVER - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_SETUP: begin
                if (cnt_done) begin
                    wr_n_d  = 1'b0;
                    state_d = ST_WR_STROBE;
                    cnt_d   = CNT_W'(WR_LOW - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_STROBE: begin
                if (cnt_done) begin
                    wr_n_d  = 1'b1;
                    state_d = ST_RECOVER;
                    cnt_d   = CNT_W'(RECOVER - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RECOVER: begin
                // Data stays driven for the first recovery cycle as write hold time.
                d_oe_d = 1'b0;
                if (cnt_done) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SIWU: begin
                if (cnt_done) begin
                    siwu_n_d     = 1'b1;
                    flush_pend_d = 1'b0;
                    idle_cnt_d   = '0;
                    state_d      = ST_RECOVER;
                    cnt_d        = CNT_W'(RECOVER - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            rxf_meta_q      <= 1'b1;
            rxf_s_q         <= 1'b1;
            txe_meta_q      <= 1'b1;
            txe_s_q         <= 1'b1;
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            idle_cnt_q      <= '0;
            rd_n_q          <= 1'b1;
            wr_n_q          <= 1'b1;
            siwu_n_q        <= 1'b1;
            d_oe_q          <= 1'b0;
            d_o_q           <= 8'h00;
            rx_data_q       <= 8'h00;
            rx_valid_q      <= 1'b0;
            flush_pend_q    <= 1'b0;
            last_grant_tx_q <= 1'b1;
        end else begin
            rxf_meta_q      <= FTDI_RXF_N;
            rxf_s_q         <= rxf_meta_q;
            txe_meta_q      <= FTDI_TXE_N;
            txe_s_q         <= txe_meta_q;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idle_cnt_q      <= idle_cnt_d;
            rd_n_q          <= rd_n_d;
            wr_n_q          <= wr_n_d;
            siwu_n_q        <= siwu_n_d;
            d_oe_q          <= d_oe_d;
            d_o_q           <= d_o_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            flush_pend_q    <= flush_pend_d;
            last_grant_tx_q <= last_grant_tx_d;
        end
    end

endmodule

// File: tb/tb_ftdi_async_fifo_ctrl.sv
// Directed bench for ftdi_async_fifo_ctrl with default parameters; expected values hand-derived from the cycle timing.
module tb_ftdi_async_fifo_ctrl;

    logic       SYSCLK, RST;
    logic       FTDI_RXF_N, FTDI_TXE_N;
    logic [7:0] FTDI_D_I, FTDI_D_O;
    logic       FTDI_D_OE, FTDI_RD_N, FTDI_WR_N, FTDI_SIWU_N;
    logic [7:0] TX_DATA, RX_DATA;
    logic       TX_VALID, TX_READY, RX_VALID, RX_READY;

    int total = 0;
    int bad   = 0;

    ftdi_async_fifo_ctrl dut (
        .SYSCLK(SYSCLK), .RST(RST),
        .FTDI_RXF_N(FTDI_RXF_N), .FTDI_TXE_N(FTDI_TXE_N),
        .FTDI_D_I(FTDI_D_I), .FTDI_D_O(FTDI_D_O), .FTDI_D_OE(FTDI_D_OE),
        .FTDI_RD_N(FTDI_RD_N), .FTDI_WR_N(FTDI_WR_N), .FTDI_SIWU_N(FTDI_SIWU_N),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    task automatic step;
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n, low, falls, reads, siwu_seen, oe_clash, xfers;
        logic prev_rd, prev_wr;
        logic [5:0] oe_exp, wr_exp;
        logic [3:0] seq;

        RST = 1'b1; FTDI_RXF_N = 1'b1; FTDI_TXE_N = 1'b1; FTDI_D_I = 8'h00;
        TX_DATA = 8'h00; TX_VALID = 1'b0; RX_READY = 1'b0;
        repeat (3) step;
        chk("rst_rd_n", FTDI_RD_N, 1);
        chk("rst_wr_n", FTDI_WR_N, 1);
        chk("rst_siwu_n", FTDI_SIWU_N, 1);
        chk("rst_d_oe", FTDI_D_OE, 0);
        chk("rst_d_o", FTDI_D_O, 0);
        chk("rst_tx_ready", TX_READY, 0);
        chk("rst_rx_valid", RX_VALID, 0);
        chk("rst_rx_data", RX_DATA, 0);
        RST = 1'b0;
        step;

        // Single read
        FTDI_D_I = 8'hA5; FTDI_RXF_N = 1'b0;
        n = 0;
        while (FTDI_RD_N && n < 20) begin step; n++; end
        chk("rd_latency", n, 3);
        chk("rd_oe_off", FTDI_D_OE, 0);
        low = 0;
        while (!FTDI_RD_N && low < 20) begin low++; step; end
        chk("rd_low_width", low, 4);
        FTDI_RXF_N = 1'b1;
        chk("rd_rx_valid", RX_VALID, 1);
        chk("rd_rx_data", RX_DATA, 8'hA5);
        falls = 0;
        repeat (20) begin step; if (!FTDI_RD_N) falls++; end
        chk("rd_no_second", falls, 0);
        RX_READY = 1'b1; step; RX_READY = 1'b0;
        chk("rd_consumed", RX_VALID, 0);

        // Single write then flush
        FTDI_TXE_N = 1'b0;
        repeat (3) step;
        TX_DATA = 8'h3C; TX_VALID = 1'b1;
        #1;
        chk("wr_tx_ready_c0", TX_READY, 1);
        step;
        chk("wr_tx_ready_c1", TX_READY, 0);
        TX_VALID = 1'b0;
        oe_exp = 6'b001111;
        wr_exp = 6'b111001;
        for (int i = 0; i < 6; i++) begin
            chk("wr_d_oe", FTDI_D_OE, oe_exp[i]);
            chk("wr_wr_n", FTDI_WR_N, wr_exp[i]);
            chk("wr_d_o", FTDI_D_O, 8'h3C);
            if (i < 5) step;
        end
        step;
        n = 0;
        while (FTDI_SIWU_N && n < 200) begin step; n++; end
        chk("wr_flush_delay", n, 65);
        low = 0;
        while (!FTDI_SIWU_N && low < 20) begin low++; step; end
        chk("wr_siwu_width", low, 2);

        // Contention: both flags drop in the same cycle, RX must win first
        FTDI_TXE_N = 1'b1;
        repeat (4) step;
        RX_READY = 1'b1; TX_DATA = 8'h5A; TX_VALID = 1'b1;
        step;
        FTDI_RXF_N = 1'b0; FTDI_TXE_N = 1'b0;
        prev_rd = FTDI_RD_N; prev_wr = FTDI_WR_N;
        seq = 4'b0; xfers = 0; oe_clash = 0; n = 0;
        while (xfers < 4 && n < 150) begin
            step; n++;
            if (FTDI_D_OE && !FTDI_RD_N) oe_clash++;
            if (prev_rd && !FTDI_RD_N) begin seq = {seq[2:0], 1'b0}; xfers++; end
            if (prev_wr && !FTDI_WR_N) begin
                seq = {seq[2:0], 1'b1}; xfers++;
                chk("cont_d_o", FTDI_D_O, 8'h5A);
            end
            prev_rd = FTDI_RD_N; prev_wr = FTDI_WR_N;
        end
        chk("cont_count", xfers, 4);
        chk("cont_order", seq, 4'b0101);
        chk("cont_oe_clash", oe_clash, 0);
        TX_VALID = 1'b0; FTDI_RXF_N = 1'b1;
        n = 0;
        while (FTDI_SIWU_N && n < 200) begin step; n++; end
        chk("cont_flush_seen", FTDI_SIWU_N, 0);
        repeat (8) step;

        // Backpressure: one read, then stall until RX_READY
        RX_READY = 1'b0; FTDI_RXF_N = 1'b0;
        falls = 0; prev_rd = FTDI_RD_N;
        repeat (40) begin
            step;
            if (prev_rd && !FTDI_RD_N) falls++;
            prev_rd = FTDI_RD_N;
        end
        chk("bp_one_read", falls, 1);
        chk("bp_rx_valid", RX_VALID, 1);
        RX_READY = 1'b1; step; RX_READY = 1'b0;
        n = 0;
        while (FTDI_RD_N && n < 10) begin step; n++; end
        chk("bp_resume", n, 1);
        FTDI_RXF_N = 1'b1; RX_READY = 1'b1;
        repeat (15) step;
        chk("bp_drained", RX_VALID, 0);

        // Flush deferral: write, then a read every 20 cycles
        TX_DATA = 8'h11; TX_VALID = 1'b1;
        n = 0;
        while (!TX_READY && n < 20) begin step; n++; end
        chk("fd_tx_ready", TX_READY, 1);
        step; TX_VALID = 1'b0;
        repeat (10) step;
        reads = 0; siwu_seen = 0; prev_rd = FTDI_RD_N;
        for (int i = 0; i < 200; i++) begin
            FTDI_RXF_N = ((i % 20) < 3) ? 1'b0 : 1'b1;
            if (!FTDI_SIWU_N) siwu_seen++;
            if (prev_rd && !FTDI_RD_N) reads++;
            prev_rd = FTDI_RD_N;
            step;
        end
        chk("fd_reads", reads, 10);
        chk("fd_no_siwu", siwu_seen, 0);
        n = 0;
        while (FTDI_SIWU_N && n < 200) begin step; n++; end
        chk("fd_flush_delay", n, 55);
        n = 0;
        while (!FTDI_SIWU_N && n < 20) begin step; n++; end
        repeat (4) step;

        // Reset in the middle of a write strobe
        TX_DATA = 8'hC3; TX_VALID = 1'b1;
        n = 0;
        while (!TX_READY && n < 20) begin step; n++; end
        chk("rw_tx_ready", TX_READY, 1);
        step; TX_VALID = 1'b0;
        n = 0;
        while (FTDI_WR_N && n < 10) begin step; n++; end
        chk("rw_wr_low", FTDI_WR_N, 0);
        RST = 1'b1;
        #1;
        chk("rw_wr_n", FTDI_WR_N, 1);
        chk("rw_d_oe", FTDI_D_OE, 0);
        chk("rw_d_o", FTDI_D_O, 0);
        FTDI_TXE_N = 1'b1;
        repeat (2) step;
        RST = 1'b0; TX_VALID = 1'b1;
        falls = 0;
        repeat (5) begin step; if (TX_READY) falls++; end
        chk("rw_no_ready", falls, 0);
        FTDI_TXE_N = 1'b0;
        n = 0;
        while (!TX_READY && n < 10) begin step; n++; end
        chk("rw_ready_latency", n, 2);
        step; TX_VALID = 1'b0;
        repeat (10) step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
